// File: rtl/conv_layer3d_seq.sv
// conv_layer3d_seq : time-multiplexed FP16 3D convolution.
// One FP16 multiply and one FP16 add are evaluated per MAC cycle. Every output
// word takes 1 INIT + K MAC + 1 WRITE cycles. A single FIN cycle follows the
// last output.
// Handshake: start is sampled only in IDLE on a rising edge. busy is high from
// that edge until FIN completes. done is a one-cycle pulse that coincides with
// busy falling. start while busy is ignored. image/filter/bias must stay stable
// for the whole run because they are read directly, not latched.
// Ports: clk, reset (async, active-high), start, image/filter/bias (flat
// buses), busy, done, outputConv (flat bus, holds the last written values),
// dbg_state_o (current FSM state).
module conv_layer3d_seq #(
   parameter int DATA_WIDTH     = 16,
   parameter int Size           = 5,
   parameter int H              = 5,
   parameter int W              = 5,
   parameter int input_channel  = 16,
   parameter int output_channel = 120,
   parameter int STRIDE         = 1,
   parameter int RELU           = 0
) (
   input  logic                                                      clk,
   input  logic                                                      reset,
   input  logic                                                      start,
   input  logic [input_channel*H*W*DATA_WIDTH-1:0]                   image,
   input  logic [output_channel*input_channel*Size*Size*DATA_WIDTH-1:0] filter,
   input  logic [output_channel*DATA_WIDTH-1:0]                      bias,
   output logic                                                      busy,
   output logic                                                      done,
   output logic [output_channel*((H-Size)/STRIDE+1)*((W-Size)/STRIDE+1)*DATA_WIDTH-1:0] outputConv,
   output logic [2:0]                                                dbg_state_o
);
   localparam int IC   = input_channel;
   localparam int OC   = output_channel;
   localparam int OH   = (H - Size) / STRIDE + 1;
   localparam int OW   = (W - Size) / STRIDE + 1;
   localparam int N    = OC * OH * OW;
   // Each counter is wide enough to hold its bound itself, not just bound-1.
   localparam int OC_W = $clog2(OC + 1);
   localparam int OH_W = $clog2(OH + 1);
   localparam int OW_W = $clog2(OW + 1);
   localparam int IC_W = $clog2(IC + 1);
   localparam int KS_W = $clog2(Size + 1);

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_MAC, S_WRITE, S_FIN} state_t;

   // Round-to-nearest-even packing of the exact value m * 2^e into FP16.
   // Covers subnormal results and overflow to infinity.
   function automatic logic [15:0] fp_pack(input logic s, input logic [47:0] m, input int e);
      int          msb, sh, ef;
      logic [47:0] kept, rem;
      logic        guard, sticky;
      logic [15:0] r;
      msb = 0;
      for (int i = 0; i < 48; i++) if (m[i]) msb = i;
      // Keep 11 significant bits, never finer than the subnormal quantum 2^-24.
      sh = (msb - 10 > -24 - e) ? msb - 10 : -24 - e;
      if (sh <= 0) begin
         kept = m << (-sh);
      end else begin
         kept   = m >> sh;
         guard  = m[sh-1];
         rem    = m & ((48'd1 << (sh - 1)) - 48'd1);
         sticky = |rem;
         if (guard && (sticky || kept[0])) kept = kept + 48'd1;
      end
      if (kept[11]) begin
         kept = kept >> 1;
         sh   = sh + 1;
      end
      ef = kept[10] ? sh + e + 25 : 0;
      if (m == '0)      r = {s, 15'd0};
      else if (ef >= 31) r = {s, 5'h1f, 10'd0};
      else               r = {s, ef[4:0], kept[9:0]};
      return r;
   endfunction

   function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
      logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      int   ea, eb;
      logic [15:0] r;
      a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != '0);
      b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != '0);
      a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == '0);
      b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == '0);
      a_zero = (a[14:0] == '0);
      b_zero = (b[14:0] == '0);
      ea = (a[14:10] == '0) ? 1 : int'(a[14:10]);
      eb = (b[14:10] == '0) ? 1 : int'(b[14:10]);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) r = 16'h7e00;
      else if (a_inf || b_inf) r = {a[15] ^ b[15], 5'h1f, 10'd0};
      else r = fp_pack(a[15] ^ b[15],
                       48'({|a[14:10], a[9:0]}) * 48'({|b[14:10], b[9:0]}),
                       ea + eb - 50);
      return r;
   endfunction

   function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
      logic a_nan, b_nan, a_inf, b_inf, s;
      int   ea, eb, emin;
      logic [47:0] xa, xb, m;
      logic [15:0] r;
      a_nan = (a[14:10] == 5'h1f) && (a[9:0] != '0);
      b_nan = (b[14:10] == 5'h1f) && (b[9:0] != '0);
      a_inf = (a[14:10] == 5'h1f) && (a[9:0] == '0);
      b_inf = (b[14:10] == 5'h1f) && (b[9:0] == '0);
      ea    = (a[14:10] == '0) ? 1 : int'(a[14:10]);
      eb    = (b[14:10] == '0) ? 1 : int'(b[14:10]);
      emin  = (ea < eb) ? ea : eb;
      // Align both operands to the smaller exponent: the sum is then exact.
      xa = 48'({|a[14:10], a[9:0]}) << (ea - emin);
      xb = 48'({|b[14:10], b[9:0]}) << (eb - emin);
      if (a[15] == b[15]) begin
         m = xa + xb; s = a[15];
      end else if (xa >= xb) begin
         m = xa - xb; s = a[15];
      end else begin
         m = xb - xa; s = b[15];
      end
      // An exact zero is -0 only when both inputs are -0.
      if (m == '0) s = a[15] & b[15];
      if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) r = 16'h7e00;
      else if (a_inf) r = a;
      else if (b_inf) r = b;
      else            r = fp_pack(s, m, emin - 25);
      return r;
   endfunction

   state_t                  state_q;
   logic                    busy_q, done_q;
   logic [15:0]             acc_q, acc_d;
   logic [N*DATA_WIDTH-1:0] out_q;
   logic [OC_W-1:0]         oc_q;
   logic [OH_W-1:0]         oy_q;
   logic [OW_W-1:0]         ox_q;
   logic [IC_W-1:0]         ic_q;
   logic [KS_W-1:0]         ky_q, kx_q;

   int          img_idx, flt_idx, out_idx;
   logic [15:0] img_w, flt_w, bias_w, prod_w, res_w;

   always_comb begin
      img_idx = int'(ic_q) * H * W + (int'(oy_q) * STRIDE + int'(ky_q)) * W
              + int'(ox_q) * STRIDE + int'(kx_q);
      flt_idx = ((int'(oc_q) * IC + int'(ic_q)) * Size + int'(ky_q)) * Size + int'(kx_q);
      out_idx = (int'(oc_q) * OH + int'(oy_q)) * OW + int'(ox_q);
      img_w   = image[img_idx*DATA_WIDTH +: DATA_WIDTH];
      flt_w   = filter[flt_idx*DATA_WIDTH +: DATA_WIDTH];
      bias_w  = bias[int'(oc_q)*DATA_WIDTH +: DATA_WIDTH];
      prod_w  = fp_mul(img_w, flt_w);
      acc_d   = fp_add(acc_q, prod_w);
      // Any set sign bit (including -0 and negative NaN) clamps to +0.
      res_w   = ((RELU != 0) && acc_q[15]) ? 16'h0000 : acc_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         acc_q   <= '0;
         out_q   <= '0;
         oc_q    <= '0;
         oy_q    <= '0;
         ox_q    <= '0;
         ic_q    <= '0;
         ky_q    <= '0;
         kx_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  busy_q  <= 1'b1;
                  oc_q    <= '0;
                  oy_q    <= '0;
                  ox_q    <= '0;
                  state_q <= S_INIT;
               end
            end
            S_INIT: begin
               acc_q   <= bias_w;
               ic_q    <= '0;
               ky_q    <= '0;
               kx_q    <= '0;
               state_q <= S_MAC;
            end
            S_MAC: begin
               acc_q <= acc_d;
               if (kx_q == KS_W'(Size - 1)) begin
                  kx_q <= '0;
                  if (ky_q == KS_W'(Size - 1)) begin
                     ky_q <= '0;
                     if (ic_q == IC_W'(IC - 1)) begin
                        ic_q    <= '0;
                        state_q <= S_WRITE;
                     end else ic_q <= ic_q + 1'b1;
                  end else ky_q <= ky_q + 1'b1;
               end else kx_q <= kx_q + 1'b1;
            end
            S_WRITE: begin
               out_q[out_idx*DATA_WIDTH +: DATA_WIDTH] <= res_w;
               state_q <= S_INIT;
               if (ox_q == OW_W'(OW - 1)) begin
                  ox_q <= '0;
                  if (oy_q == OH_W'(OH - 1)) begin
                     oy_q <= '0;
                     if (oc_q == OC_W'(OC - 1)) begin
                        oc_q    <= '0;
                        state_q <= S_FIN;
                     end else oc_q <= oc_q + 1'b1;
                  end else oy_q <= oy_q + 1'b1;
               end else ox_q <= ox_q + 1'b1;
            end
            S_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign outputConv  = out_q;
   assign dbg_state_o = state_q;
endmodule

// File: tb/tb_conv_layer3d_seq.sv
// Bench for conv_layer3d_seq. Three instances with different geometries:
//   0: 3x3 image, 2x2 kernel, 1->1 channel, stride 1, no ReLU
//   1: 5x5 image, 3x3 kernel, 1->2 channels, stride 2, no ReLU
//   2: 4x4 image, 2x2 kernel, 2->2 channels, stride 2, ReLU
// Expected words come from a real-arithmetic FP16 model (exact products and
// sums in double precision, then round-to-nearest-even to FP16).
module tb_conv_layer3d_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [2:0] start_v, busy_v, done_v;
   logic [2:0] dbg_a, dbg_b, dbg_c;

   logic [9*16-1:0]  img_a;  logic [4*16-1:0]  flt_a;  logic [16-1:0] bias_a;  logic [4*16-1:0] out_a;
   logic [25*16-1:0] img_b;  logic [18*16-1:0] flt_b;  logic [32-1:0] bias_b;  logic [8*16-1:0] out_b;
   logic [32*16-1:0] img_c;  logic [16*16-1:0] flt_c;  logic [32-1:0] bias_c;  logic [8*16-1:0] out_c;

   conv_layer3d_seq #(.DATA_WIDTH(16), .Size(2), .H(3), .W(3), .input_channel(1),
      .output_channel(1), .STRIDE(1), .RELU(0)) u_a (
      .clk(clk), .reset(reset), .start(start_v[0]), .image(img_a), .filter(flt_a),
      .bias(bias_a), .busy(busy_v[0]), .done(done_v[0]), .outputConv(out_a), .dbg_state_o(dbg_a));
   conv_layer3d_seq #(.DATA_WIDTH(16), .Size(3), .H(5), .W(5), .input_channel(1),
      .output_channel(2), .STRIDE(2), .RELU(0)) u_b (
      .clk(clk), .reset(reset), .start(start_v[1]), .image(img_b), .filter(flt_b),
      .bias(bias_b), .busy(busy_v[1]), .done(done_v[1]), .outputConv(out_b), .dbg_state_o(dbg_b));
   conv_layer3d_seq #(.DATA_WIDTH(16), .Size(2), .H(4), .W(4), .input_channel(2),
      .output_channel(2), .STRIDE(2), .RELU(1)) u_c (
      .clk(clk), .reset(reset), .start(start_v[2]), .image(img_c), .filter(flt_c),
      .bias(bias_c), .busy(busy_v[2]), .done(done_v[2]), .outputConv(out_c), .dbg_state_o(dbg_c));

   int cfg_h[3]    = '{3, 5, 4};
   int cfg_w[3]    = '{3, 5, 4};
   int cfg_sz[3]   = '{2, 3, 2};
   int cfg_ic[3]   = '{1, 1, 2};
   int cfg_oc[3]   = '{1, 2, 2};
   int cfg_st[3]   = '{1, 2, 2};
   int cfg_relu[3] = '{0, 0, 1};

   int          chk_total = 0;
   int          chk_bad   = 0;
   int          last_lat;
   logic [15:0] w0_before, w0_after;
   logic [15:0] exp_q[$];
   logic [15:0] img_q[$], flt_q[$], bs_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_total++;
      if (got !== exp) begin
         chk_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int oh_of(input int i); return (cfg_h[i] - cfg_sz[i]) / cfg_st[i] + 1; endfunction
   function automatic int ow_of(input int i); return (cfg_w[i] - cfg_sz[i]) / cfg_st[i] + 1; endfunction
   function automatic int k_of(input int i);  return cfg_ic[i] * cfg_sz[i] * cfg_sz[i]; endfunction
   function automatic int n_of(input int i);  return cfg_oc[i] * oh_of(i) * ow_of(i); endfunction
   function automatic int lat_of(input int i); return n_of(i) * (k_of(i) + 2) + 1; endfunction

   // ---------------- FP16 reference arithmetic ----------------
   function automatic real h2r(input logic [15:0] h);
      real m;
      int  ex;
      ex = int'(h[14:10]);
      if (ex == 0) m = real'(h[9:0]) * 2.0 ** (-24);
      else         m = real'(1024 + int'(h[9:0])) * 2.0 ** (ex - 25);
      return h[15] ? -m : m;
   endfunction

   function automatic logic [15:0] r2h(input real x);
      logic [63:0] bits;
      logic        s;
      real         a, n;
      int          e, k;
      logic [15:0] r;
      bits = $realtobits(x);
      s    = bits[63];
      a    = s ? -x : x;
      if (a == 0.0) r = {s, 15'd0};
      else if (a >= 65520.0) r = {s, 5'h1f, 10'd0};
      else begin
         e = 0;
         while (e < 15 && a >= 2.0 ** (e + 1)) e++;
         while (e > -14 && a < 2.0 ** e) e--;
         n = a / 2.0 ** (e - 10);
         k = $rtoi(n);
         if ((n - k > 0.5) || ((n - k == 0.5) && (k % 2 == 1))) k++;
         if (k >= 2048) begin k = 1024; e++; end
         if (k >= 1024) r = {s, 5'(e + 15), 10'(k - 1024)};
         else           r = {s, 5'd0, 10'(k)};
      end
      return r;
   endfunction

   // Pushes the expected output words of instance idx, in bus order.
   function automatic void ref_conv(input int idx);
      int h, w, sz, ic, st;
      logic [15:0] acc, p;
      h = cfg_h[idx]; w = cfg_w[idx]; sz = cfg_sz[idx]; ic = cfg_ic[idx]; st = cfg_st[idx];
      for (int o = 0; o < cfg_oc[idx]; o++)
         for (int oy = 0; oy < oh_of(idx); oy++)
            for (int ox = 0; ox < ow_of(idx); ox++) begin
               acc = bs_q[o];
               for (int c = 0; c < ic; c++)
                  for (int ky = 0; ky < sz; ky++)
                     for (int kx = 0; kx < sz; kx++) begin
                        p   = r2h(h2r(img_q[c*h*w + (oy*st + ky)*w + ox*st + kx]) *
                                  h2r(flt_q[((o*ic + c)*sz + ky)*sz + kx]));
                        acc = r2h(h2r(acc) + h2r(p));
                     end
               if (cfg_relu[idx] != 0 && acc[15]) acc = 16'h0000;
               exp_q.push_back(acc);
            end
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic logic [15:0] rand_half();
      if ($urandom_range(0, 7) == 0) return 16'h0000;
      return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 18)), 10'($urandom_range(0, 1023))};
   endfunction

   task automatic fill_const(input int idx, input logic [15:0] iv, input logic [15:0] fv, input logic [15:0] bv);
      img_q.delete(); flt_q.delete(); bs_q.delete();
      for (int i = 0; i < cfg_ic[idx]*cfg_h[idx]*cfg_w[idx]; i++) img_q.push_back(iv);
      for (int i = 0; i < cfg_oc[idx]*k_of(idx); i++) flt_q.push_back(fv);
      for (int i = 0; i < cfg_oc[idx]; i++) bs_q.push_back(bv);
   endtask

   task automatic fill_rand(input int idx);
      img_q.delete(); flt_q.delete(); bs_q.delete();
      for (int i = 0; i < cfg_ic[idx]*cfg_h[idx]*cfg_w[idx]; i++) img_q.push_back(rand_half());
      for (int i = 0; i < cfg_oc[idx]*k_of(idx); i++) flt_q.push_back(rand_half());
      for (int i = 0; i < cfg_oc[idx]; i++) bs_q.push_back(rand_half());
   endtask

   task automatic load(input int idx);
      @(negedge clk);
      for (int i = 0; i < img_q.size(); i++)
         case (idx)
            0:       img_a[i*16 +: 16] = img_q[i];
            1:       img_b[i*16 +: 16] = img_q[i];
            default: img_c[i*16 +: 16] = img_q[i];
         endcase
      for (int i = 0; i < flt_q.size(); i++)
         case (idx)
            0:       flt_a[i*16 +: 16] = flt_q[i];
            1:       flt_b[i*16 +: 16] = flt_q[i];
            default: flt_c[i*16 +: 16] = flt_q[i];
         endcase
      for (int i = 0; i < bs_q.size(); i++)
         case (idx)
            0:       bias_a[i*16 +: 16] = bs_q[i];
            1:       bias_b[i*16 +: 16] = bs_q[i];
            default: bias_c[i*16 +: 16] = bs_q[i];
         endcase
   endtask

   function automatic logic [15:0] get_out(input int idx, input int n);
      case (idx)
         0:       return out_a[n*16 +: 16];
         1:       return out_b[n*16 +: 16];
         default: return out_c[n*16 +: 16];
      endcase
   endfunction

   // Start one run; optionally re-pulse start at cycle 'poke' of the run.
   task automatic run_dut(input int idx, input int poke, input string tag);
      int cyc;
      bit seen;
      @(negedge clk);
      start_v[idx] = 1'b1;
      @(posedge clk); #1;
      start_v[idx] = 1'b0;
      check_val({tag, "_busy_on"}, 32'(busy_v[idx]), 1);
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 5000) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == k_of(idx) + 1) w0_before = get_out(idx, 0);
         if (cyc == k_of(idx) + 2) w0_after  = get_out(idx, 0);
         start_v[idx] = (cyc == poke);
         if (done_v[idx]) seen = 1;
      end
      start_v[idx] = 1'b0;
      last_lat = cyc;
      check_val({tag, "_latency"}, cyc, lat_of(idx));
      check_val({tag, "_busy_at_done"}, 32'(busy_v[idx]), 0);
      @(posedge clk); #1;
      check_val({tag, "_done_width"}, 32'(done_v[idx]), 0);
   endtask

   task automatic compare_all(input int idx, input string tag);
      logic [15:0] e;
      check_val({tag, "_nexp"}, exp_q.size(), n_of(idx));
      for (int n = 0; n < n_of(idx); n++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hdead;
         check_val($sformatf("%s_w%0d", tag, n), get_out(idx, n), e);
      end
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_cnt;
      reset = 1'b1; start_v = '0;
      img_a = '0; flt_a = '0; bias_a = '0;
      img_b = '0; flt_b = '0; bias_b = '0;
      img_c = '0; flt_c = '0; bias_c = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy", 32'(busy_v), 0);
      check_val("rst_done", 32'(done_v), 0);
      check_val("rst_out_a", 32'(|out_a), 0);
      check_val("rst_out_bc", 32'(|{out_b, out_c}), 0);
      @(negedge clk); reset = 1'b0;

      // All-ones 2x2 kernel over a 3x3 image: every output is 4.0.
      fill_const(0, 16'h3c00, 16'h3c00, 16'h0000); load(0); ref_conv(0);
      run_dut(0, -1, "ones");
      check_val("ones_lat25", last_lat, 25);
      check_val("ones_w0_before", w0_before, 16'h0000);
      check_val("ones_w0_after", w0_after, 16'h4400);
      check_val("ones_w3_const", get_out(0, 3), 16'h4400);
      compare_all(0, "ones");

      // A start pulse mid-run must not disturb timing or results.
      ref_conv(0);
      run_dut(0, 5, "poke");
      compare_all(0, "poke");

      // Reset ten cycles into a run.
      @(negedge clk); start_v[0] = 1'b1;
      @(posedge clk); #1; start_v[0] = 1'b0;
      repeat (10) @(posedge clk);
      #1; reset = 1'b1; #1;
      check_val("midrst_busy", 32'(busy_v[0]), 0);
      check_val("midrst_done", 32'(done_v[0]), 0);
      check_val("midrst_out", 32'(|out_a), 0);
      @(negedge clk); reset = 1'b0;
      done_cnt = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done_v[0]) done_cnt++;
      end
      check_val("midrst_no_done", done_cnt, 0);
      ref_conv(0);
      run_dut(0, -1, "restart");
      compare_all(0, "restart");

      // Zero filter, bias -2.0: plain result and ReLU-clamped result.
      fill_const(0, 16'h3c00, 16'h0000, 16'hc000); load(0); ref_conv(0);
      run_dut(0, -1, "neg");
      check_val("neg_w0_const", get_out(0, 0), 16'hc000);
      compare_all(0, "neg");
      fill_const(2, 16'h3c00, 16'h0000, 16'hc000); load(2); ref_conv(2);
      run_dut(2, -1, "relu");
      check_val("relu_w0_const", get_out(2, 0), 16'h0000);
      compare_all(2, "relu");

      // Stride-2 ramp: image(r,c) = r*5+c, unit filter, bias {0, 1.0}.
      fill_const(1, 16'h0000, 16'h3c00, 16'h0000);
      for (int i = 0; i < 25; i++) img_q[i] = r2h(real'(i));
      bs_q[1] = 16'h3c00;
      load(1); ref_conv(1);
      run_dut(1, -1, "ramp");
      check_val("ramp_oc0_0", get_out(1, 0), 16'h52c0);
      check_val("ramp_oc0_1", get_out(1, 1), 16'h5480);
      check_val("ramp_oc0_2", get_out(1, 2), 16'h5880);
      check_val("ramp_oc0_3", get_out(1, 3), 16'h5910);
      compare_all(1, "ramp");

      // Randomized runs on every geometry.
      for (int it = 0; it < 3; it++)
         for (int idx = 0; idx < 3; idx++) begin
            fill_rand(idx); load(idx); ref_conv(idx);
            run_dut(idx, (it == 1) ? 3 : -1, $sformatf("rnd%0d_%0d", it, idx));
            compare_all(idx, $sformatf("rnd%0d_%0d", it, idx));
         end

      $display("test done: total=%0d bad=%0d", chk_total, chk_bad);
      $finish;
   end
endmodule
